// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//   Multi-cycle WIDTH x WIDTH integer multiplier for MIPS32 mult/multu.
//   One add-and-shift iteration per cycle on a single WIDTH-bit adder.
//   Signed operands are reduced to magnitudes up front, multiplied
//   unsigned, and the 2*WIDTH-bit product is negated in a final SIGN cycle.
//
//   Latency: start sampled at edge t -> done_out / new HI/LO in cycle
//   t+WIDTH+2. Back-to-back issue is allowed from DONE.
//
// Ports
//   clk_in     system clock, rising edge
//   rst_in     synchronous active-high reset
//   start_in   request a multiply (honoured only in IDLE or DONE)
//   signed_in  1 = mult (two's complement), 0 = multu
//   A_in       multiplicand
//   B_in       multiplier
//   busy_out   operation in progress (RUN or SIGN)
//   done_out   one-cycle pulse: HI_out/LO_out just updated
//   HI_out     upper WIDTH bits of the product
//   LO_out     lower WIDTH bits of the product
// ---------------------------------------------------------------------------
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             signed_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out
);

  // Counter must hold 0..WIDTH.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SIGN,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [WIDTH-1:0]    r_mcand;   // |A|
  logic [WIDTH-1:0]    r_mplier;  // |B|, shifted right each iteration
  logic [2*WIDTH-1:0]  r_acc;     // partial product
  logic                r_neg;     // final product must be negated
  logic [CW-1:0]       r_count;
  logic [WIDTH-1:0]    r_hi;
  logic [WIDTH-1:0]    r_lo;

  logic                w_accept;
  logic                w_last;
  logic [WIDTH-1:0]    w_abs_a;
  logic [WIDTH-1:0]    w_abs_b;
  logic [WIDTH:0]      w_sum;
  logic [2*WIDTH-1:0]  w_prod;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  assign w_accept = start_in && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_count == CW'(WIDTH - 1));

  // Negating the most-negative value wraps back to itself, which read as
  // unsigned is exactly its magnitude, so no extra bit is needed.
  assign w_abs_a = (signed_in && A_in[WIDTH-1]) ? (~A_in + WIDTH'(1)) : A_in;
  assign w_abs_b = (signed_in && B_in[WIDTH-1]) ? (~B_in + WIDTH'(1)) : B_in;

  // Upper-half add with the carry kept; it is shifted back in on the right
  // shift below so nothing is lost.
  assign w_sum = r_mplier[0] ? ({1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand})
                             : {1'b0, r_acc[2*WIDTH-1:WIDTH]};

  // Negating zero yields zero, so a zero operand never leaves a -0 pattern.
  assign w_prod = r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start_in) w_next = S_RUN;
      S_RUN:  if (w_last)   w_next = S_SIGN;
      S_SIGN:               w_next = S_DONE;
      S_DONE: w_next = start_in ? S_RUN : S_IDLE;
      default:              w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_count  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_accept) begin
        r_mcand  <= w_abs_a;
        r_mplier <= w_abs_b;
        r_neg    <= signed_in & (A_in[WIDTH-1] ^ B_in[WIDTH-1]);
        r_acc    <= '0;
        r_count  <= '0;
      end else if (r_state == S_RUN) begin
        // {carry, acc} >> 1
        r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count + CW'(1);
      end

      // Result registers only move at the end of SIGN, so they hold the
      // last product through IDLE and any following operation.
      if (r_state == S_SIGN) begin
        r_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_lo <= w_prod[WIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: all derived from flops only
  // ---------------------------------------------------------------------
  assign busy_out = (r_state == S_RUN) || (r_state == S_SIGN);
  assign done_out = (r_state == S_DONE);
  assign HI_out   = r_hi;
  assign LO_out   = r_lo;

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
//   Directed bench for seq_multiplier (WIDTH=32): a table of operand/product
//   vectors checked for value and cycle timing, plus hand-written sequences
//   for start-while-busy, back-to-back issue and reset mid-operation.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic        signed_in;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic        busy_out;
  logic        done_out;
  logic [31:0] HI_out;
  logic [31:0] LO_out;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [63:0] prev_prod;

  seq_multiplier #(.WIDTH(32)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start_in  (start_in),
    .signed_in (signed_in),
    .A_in      (A_in),
    .B_in      (B_in),
    .busy_out  (busy_out),
    .done_out  (done_out),
    .HI_out    (HI_out),
    .LO_out    (LO_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Call at a negedge; the following posedge is the sampling edge t.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    start_in  = 1'b1;
    signed_in = s;
    A_in      = a;
    B_in      = b;
  endtask

  // Loop index k = number of negedges since the start was driven; k=1 is the
  // first cycle after the sampling edge. Expect busy for k=1..33, done at 34.
  task automatic run_vec(input string nm, input vec_t v);
    int          done_k, busy_n, n_done;
    logic        overlap;
    logic [63:0] got;
    done_k = 0; busy_n = 0; n_done = 0; overlap = 1'b0; got = '0;
    @(negedge clk_in);
    issue(v.s, v.a, v.b);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk_in);
      if (busy_out) busy_n++;
      if (done_out) begin
        n_done++;
        if (done_k == 0) begin
          done_k = k;
          got    = {HI_out, LO_out};
        end
      end
      if (busy_out && done_out) overlap = 1'b1;
      if (k == 33) chk({nm, "_hold"}, {HI_out, LO_out}, prev_prod);
      if (k == 1) start_in = 1'b0;
    end
    chk({nm, "_done_cycle"}, 64'(done_k), 64'd34);
    chk({nm, "_done_pulses"}, 64'(n_done), 64'd1);
    chk({nm, "_busy_cycles"}, 64'(busy_n), 64'd33);
    chk({nm, "_overlap"}, 64'(overlap), 64'd0);
    chk({nm, "_hi"}, 64'(got[63:32]), 64'(v.hi));
    chk({nm, "_lo"}, 64'(got[31:0]), 64'(v.lo));
    prev_prod = {v.hi, v.lo};
  endtask

  initial begin
    int          n_done, dk1, dk2;
    logic        b35;
    logic [63:0] got1, got2;
    vec_t        v;

    rst_in = 1'b1; start_in = 1'b0; signed_in = 1'b0; A_in = '0; B_in = '0;
    repeat (3) @(negedge clk_in);
    chk("reset_busy", 64'(busy_out), 64'd0);
    chk("reset_done", 64'(done_out), 64'd0);
    chk("reset_hi",   64'(HI_out),   64'd0);
    chk("reset_lo",   64'(LO_out),   64'd0);
    rst_in    = 1'b0;
    prev_prod = '0;

    //            s     A             B             HI            LO
    vecs[0]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[4]  = '{1'b1, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000};
    vecs[5]  = '{1'b0, 32'h00000007, 32'h00000006, 32'h00000000, 32'h0000002A};
    vecs[6]  = '{1'b0, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[7]  = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
    vecs[8]  = '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[9]  = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[10] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};

    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Start while busy, then back-to-back issue from DONE.
    n_done = 0; dk1 = 0; dk2 = 0; b35 = 1'b0; got1 = '0; got2 = '0;
    @(negedge clk_in);
    issue(1'b0, 32'd7, 32'd6);
    for (int k = 1; k <= 72; k++) begin
      @(negedge clk_in);
      if (done_out) begin
        n_done++;
        if (dk1 == 0) begin
          dk1 = k; got1 = {HI_out, LO_out};
        end else if (dk2 == 0) begin
          dk2 = k; got2 = {HI_out, LO_out};
        end
      end
      if (k == 35) b35 = busy_out;
      if (k == 1 || k == 11 || k == 35) start_in = 1'b0;
      if (k == 10 || k == 34) issue(1'b0, 32'd2, 32'd2);
    end
    chk("b2b_first_done_cycle", 64'(dk1), 64'd34);
    chk("b2b_first_result", got1, 64'd42);
    chk("b2b_busy_after_done", 64'(b35), 64'd1);
    chk("b2b_second_done_cycle", 64'(dk2), 64'd68);
    chk("b2b_second_result", got2, 64'd4);
    chk("b2b_done_pulses", 64'(n_done), 64'd2);
    prev_prod = 64'd4;

    // Prior result of 42, then reset in the middle of a 3x3.
    v = '{1'b0, 32'd7, 32'd6, 32'd0, 32'd42};
    run_vec("pre_reset", v);
    @(negedge clk_in);
    issue(1'b0, 32'd3, 32'd3);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk_in);
      if (k == 1) start_in = 1'b0;
      if (k == 14) rst_in = 1'b1;
    end
    @(negedge clk_in);
    chk("midrst_busy", 64'(busy_out), 64'd0);
    chk("midrst_done", 64'(done_out), 64'd0);
    chk("midrst_hi",   64'(HI_out),   64'd0);
    chk("midrst_lo",   64'(LO_out),   64'd0);
    rst_in = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk_in);
      if (done_out) n_done++;
    end
    chk("midrst_no_done", 64'(n_done), 64'd0);
    prev_prod = '0;
    v = '{1'b0, 32'd3, 32'd3, 32'd0, 32'd9};
    run_vec("post_reset", v);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
